// File: rtl/npu_cmd_dispatch_pkg.sv
// Shared types and constants for the NPU command dispatcher.
// Contents: command opcodes, FSM state codes, the 25-bit frame payload,
// error-bit indices and a tile address helper.
package npu_cmd_pkg;

  // Command opcodes carried in the frame cmd byte
  localparam logic [7:0] CMD_WR_TILE   = 8'h01;
  localparam logic [7:0] CMD_RD_TILE   = 8'h02;
  localparam logic [7:0] CMD_START_OP  = 8'h03;
  localparam logic [7:0] CMD_RD_STATUS = 8'h04;
  localparam logic [7:0] CMD_CLR_ERR   = 8'h05;

  // Dispatcher FSM state codes
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_EXEC      = 2'd1;
  localparam state_t ST_WAIT_ACK  = 2'd2;
  localparam state_t ST_WAIT_DONE = 2'd3;

  // Decoded SPI frame as stored in the FIFO (25 bits)
  typedef struct packed {
    logic [7:0] cmd;
    logic [2:0] tile_i;
    logic [2:0] tile_j;
    logic [2:0] op_code;
    logic [7:0] data_in;
  } frame_t;

  // Bit positions inside the sticky err vector {tmo, ill, ovf}
  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_ILL = 1;
  localparam int unsigned ERR_TMO = 2;

  // Tile store address {i,j} of a frame
  function automatic logic [5:0] tile_addr(input frame_t f);
    return {f.tile_i, f.tile_j};
  endfunction

endpackage

// File: rtl/npu_cmd_dispatch_if.sv
// Bus bundle between the dispatcher and its neighbours (spi_slave frame
// side, compute engine request side, engine tile read port, status).
// slave  : the dispatcher's view.
// master : the view of whatever drives frames / acks and observes results.
interface npu_cmd_dispatch_if;
  logic       valid;
  logic [7:0] cmd;
  logic [2:0] tile_i;
  logic [2:0] tile_j;
  logic [2:0] op_code;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       op_req;
  logic       op_ack;
  logic       op_done;
  logic [2:0] op_sel;
  logic [5:0] op_tile;
  logic [5:0] tile_rd_addr;
  logic [7:0] tile_rd_data;
  logic       busy;
  logic [2:0] err;

  modport slave (
    input  valid, cmd, tile_i, tile_j, op_code, data_in,
    input  op_ack, op_done, tile_rd_addr,
    output data_out, op_req, op_sel, op_tile, tile_rd_data, busy, err
  );

  modport master (
    output valid, cmd, tile_i, tile_j, op_code, data_in,
    output op_ack, op_done, tile_rd_addr,
    input  data_out, op_req, op_sel, op_tile, tile_rd_data, busy, err
  );
endinterface

// File: rtl/npu_cmd_dispatch_fifo.sv
// Frame FIFO for the NPU command dispatcher.
// Ports: clk/rst (async active-high), push_i/pop_i, wdata_i (frame),
// rdata_c (head entry, combinational), full_c/empty_c (combinational flags),
// count_o (registered occupancy 0..DEPTH).
// The caller guarantees push_i is only asserted when not full or popping.
module npu_cmd_fifo
  import npu_cmd_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  frame_t        wdata_i,
  output frame_t        rdata_c,
  output logic          full_c,
  output logic          empty_c,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  frame_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointer increment with explicit modulo-DEPTH wrap
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/npu_cmd_dispatch.sv
// NPU command dispatcher: buffers decoded SPI frames, then executes them
// against an 8x8 byte tile store or the compute engine.
// Ports: clk, rst (async active-high), bus (npu_cmd_dispatch_if.slave):
//   frame in (valid/cmd/tile_i/tile_j/op_code/data_in), response data_out,
//   compute handshake (op_req/op_ack/op_done/op_sel/op_tile),
//   engine tile read (tile_rd_addr/tile_rd_data), busy, sticky err.
// Optional: NPU_DISPATCH_TIMEOUT_EN adds the TIMEOUT_CYCLES WAIT_DONE watchdog.
module npu_cmd_dispatch
  import npu_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
`ifdef NPU_DISPATCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  npu_cmd_dispatch_if.slave       bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  frame_t        fifo_wdata, fifo_head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf;
  logic [CW-1:0] fifo_count;

  state_t        state_q, state_d;
  frame_t        frame_q, frame_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          op_req_q, op_req_d;
  logic [2:0]    op_sel_q, op_sel_d;
  logic [5:0]    op_tile_q, op_tile_d;
  logic [2:0]    err_q, err_d;
  logic          busy_q, busy_d;

  logic [7:0]    mem_q [64];
  logic          mem_we;
  logic [5:0]    mem_waddr;
  logic [7:0]    mem_wdata;

`ifdef NPU_DISPATCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Frame capture; a full FIFO still accepts when IDLE pops in the same cycle
  assign fifo_wdata = '{cmd: bus.cmd, tile_i: bus.tile_i, tile_j: bus.tile_j,
                        op_code: bus.op_code, data_in: bus.data_in};
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_push  = bus.valid && (!fifo_full || fifo_pop);
  assign fifo_ovf   = bus.valid && fifo_full && !fifo_pop;

  npu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_c (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    data_out_d = data_out_q;
    op_req_d   = op_req_q;
    op_sel_d   = op_sel_q;
    op_tile_d  = op_tile_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_waddr  = tile_addr(frame_q);
    mem_wdata  = frame_q.data_in;
`ifdef NPU_DISPATCH_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          frame_d = fifo_head;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_IDLE;
        case (frame_q.cmd)
          CMD_WR_TILE:   mem_we = 1'b1;
          CMD_RD_TILE:   data_out_d = mem_q[tile_addr(frame_q)];
          CMD_START_OP: begin
            op_req_d  = 1'b1;
            op_sel_d  = frame_q.op_code;
            op_tile_d = tile_addr(frame_q);
            state_d   = ST_WAIT_ACK;
          end
          CMD_RD_STATUS: data_out_d = {1'b1, err_q[ERR_TMO], err_q[ERR_ILL],
                                       err_q[ERR_OVF], 1'b0, 3'(fifo_count)};
          CMD_CLR_ERR:   err_d = '0;
          default:       err_d[ERR_ILL] = 1'b1;
        endcase
      end

      ST_WAIT_ACK: begin
        if (bus.op_ack) begin
          op_req_d = 1'b0;
          state_d  = bus.op_done ? ST_IDLE : ST_WAIT_DONE;
`ifdef NPU_DISPATCH_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end

      ST_WAIT_DONE: begin
        if (bus.op_done) begin
          state_d = ST_IDLE;
`ifdef NPU_DISPATCH_TIMEOUT_EN
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d[ERR_TMO] = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Overflow applied last so it survives a CLR_ERR in the same cycle
    if (fifo_ovf) err_d[ERR_OVF] = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      data_out_q <= '0;
      op_req_q   <= 1'b0;
      op_sel_q   <= '0;
      op_tile_q  <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
`ifdef NPU_DISPATCH_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      data_out_q <= data_out_d;
      op_req_q   <= op_req_d;
      op_sel_q   <= op_sel_d;
      op_tile_q  <= op_tile_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
`ifdef NPU_DISPATCH_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  // 8x8 tile store, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) mem_q[k] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.op_req       = op_req_q;
  assign bus.op_sel       = op_sel_q;
  assign bus.op_tile      = op_tile_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
  assign bus.tile_rd_data = mem_q[bus.tile_rd_addr];

endmodule

// File: tb/tb_npu_cmd_dispatch.sv
// Self-checking bench for npu_cmd_dispatch: directed scenarios followed by
// randomized tile traffic, checked against a behavioural tile/err model.
module tb_npu_cmd_dispatch;
  import npu_cmd_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef NPU_DISPATCH_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  npu_cmd_dispatch_if bus ();

  npu_cmd_dispatch #(
    .FIFO_DEPTH(DEPTH)
`ifdef NPU_DISPATCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] ref_mem [64];
  logic [2:0] ref_err;      // {tmo, ill, ovf}
  logic [7:0] ref_dout;
  logic [7:0] rd;
  logic [7:0] wd [6];
  logic [5:0] a;
  int         hi_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [2:0] i, input logic [2:0] j,
                      input logic [2:0] op, input logic [7:0] d);
    bus.valid   = 1'b1;
    bus.cmd     = c;
    bus.tile_i  = i;
    bus.tile_j  = j;
    bus.op_code = op;
    bus.data_in = d;
    tick();
    bus.valid   = 1'b0;
  endtask

  task automatic peek(input logic [5:0] addr, output logic [7:0] data);
    bus.tile_rd_addr = addr;
    #1;
    data = bus.tile_rd_data;
  endtask

  task automatic wait_op_req();
    int k;
    k = 0;
    while (bus.op_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("op_req_rise", 8'(bus.op_req), 8'h01);
  endtask

  function automatic logic [7:0] status_byte(input int unsigned cnt);
    return {1'b1, ref_err, 1'b0, 3'(cnt)};
  endfunction

  initial begin
    rst = 1'b1;
    bus.valid = 1'b0; bus.cmd = '0; bus.tile_i = '0; bus.tile_j = '0;
    bus.op_code = '0; bus.data_in = '0; bus.op_ack = 1'b0; bus.op_done = 1'b0;
    bus.tile_rd_addr = '0;
    for (int k = 0; k < 64; k++) ref_mem[k] = 8'h00;
    ref_err  = 3'b000;
    ref_dout = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_data_out", bus.data_out, 8'h00);
    chk("rst_op_req",   8'(bus.op_req), 8'h00);
    chk("rst_op_sel",   8'(bus.op_sel), 8'h00);
    chk("rst_op_tile",  8'(bus.op_tile), 8'h00);
    chk("rst_err",      8'(bus.err), 8'h00);
    chk("rst_busy",     8'(bus.busy), 8'h00);
    peek(6'h15, rd); chk("rst_mem_15", rd, 8'h00);

    // Stray op_done while idle is ignored
    bus.op_done = 1'b1; tick(); bus.op_done = 1'b0;
    chk("stray_done_busy", 8'(bus.busy), 8'h00);

    // WR_TILE then RD_TILE at (2,5)
    send(CMD_WR_TILE, 3'd2, 3'd5, 3'd0, 8'hA7); ref_mem[6'h15] = 8'hA7;
    tick(); tick();
    peek(6'h15, rd); chk("wr_tile_rd_port", rd, ref_mem[6'h15]);
    send(CMD_RD_TILE, 3'd2, 3'd5, 3'd0, 8'h00); ref_dout = ref_mem[6'h15];
    tick(); tick();
    chk("rd_tile_data_out", bus.data_out, ref_dout);

    // Back-to-back write then read of the same address
    send(CMD_WR_TILE, 3'd3, 3'd3, 3'd0, 8'h5C); ref_mem[6'h1B] = 8'h5C;
    send(CMD_RD_TILE, 3'd3, 3'd3, 3'd0, 8'h00); ref_dout = ref_mem[6'h1B];
    repeat (3) tick();
    chk("b2b_wr_rd", bus.data_out, ref_dout);

    // START_OP op=3 (1,7): ack after 5 clk, done 20 clk later
    send(CMD_START_OP, 3'd1, 3'd7, 3'd3, 8'h00);
    wait_op_req();
    hi_cnt = 1;
    chk("op_sel",  8'(bus.op_sel), 8'h03);
    chk("op_tile", 8'(bus.op_tile), 8'h0F);
    chk("op_busy", 8'(bus.busy), 8'h01);
    repeat (4) begin
      tick();
      if (bus.op_req === 1'b1) hi_cnt++;
    end
    bus.op_ack = 1'b1; tick(); bus.op_ack = 1'b0;
    if (bus.op_req === 1'b1) hi_cnt++;
    chk("op_req_width", 8'(hi_cnt), 8'd5);
    send(CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00);
    send(CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00);
    repeat (18) tick();
    chk("wait_done_busy",  8'(bus.busy), 8'h01);
    chk("wait_done_dout",  bus.data_out, ref_dout);
    chk("wait_done_req",   8'(bus.op_req), 8'h00);
    bus.op_done = 1'b1; tick(); bus.op_done = 1'b0;
    chk("done_busy", 8'(bus.busy), 8'h00);
    tick(); tick();
    ref_dout = status_byte(1);
    chk("status_cnt1", bus.data_out, ref_dout);
    tick(); tick();
    ref_dout = status_byte(0);
    chk("status_cnt0", bus.data_out, ref_dout);

    // Overflow: 5 frames into a 4-deep FIFO while blocked in WAIT_DONE
    send(CMD_START_OP, 3'd0, 3'd0, 3'd1, 8'h00);
    wait_op_req();
    bus.op_ack = 1'b1; tick(); bus.op_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wd[k] = 8'($urandom_range(1, 255));
      send(CMD_WR_TILE, 3'd1, 3'(k), 3'd0, wd[k]);
      if (k < 4) ref_mem[8 + k] = wd[k];
    end
    ref_err[0] = 1'b1;
    chk("ovf_err", 8'(bus.err), 8'(ref_err));
    bus.op_done = 1'b1; tick(); bus.op_done = 1'b0;
    // Full FIFO with a simultaneous pop accepts the frame
    wd[5] = 8'($urandom_range(1, 255));
    send(CMD_WR_TILE, 3'd1, 3'd5, 3'd0, wd[5]); ref_mem[13] = wd[5];
    chk("full_pop_push_err", 8'(bus.err), 8'(ref_err));
    repeat (14) tick();
    for (int k = 0; k < 6; k++) begin
      peek(6'(8 + k), rd);
      chk($sformatf("ovf_mem_%0d", 8 + k), rd, ref_mem[8 + k]);
    end
    send(CMD_CLR_ERR, 3'd0, 3'd0, 3'd0, 8'h00); ref_err = 3'b000;
    tick(); tick();
    chk("clr_err", 8'(bus.err), 8'(ref_err));

    // Illegal command: err_ill only, no side effects
    send(8'hFF, 3'd2, 3'd5, 3'd0, 8'h11); ref_err[1] = 1'b1;
    tick(); tick();
    chk("ill_err",  8'(bus.err), 8'(ref_err));
    chk("ill_dout", bus.data_out, ref_dout);
    peek(6'h15, rd); chk("ill_mem", rd, ref_mem[6'h15]);
    send(CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00); ref_dout = status_byte(0);
    tick(); tick();
    chk("ill_status", bus.data_out, ref_dout);
    send(CMD_CLR_ERR, 3'd0, 3'd0, 3'd0, 8'h00); ref_err = 3'b000;
    tick(); tick();
    chk("ill_clr", 8'(bus.err), 8'(ref_err));

`ifdef NPU_DISPATCH_TIMEOUT_EN
    // Watchdog: no op_done for TMO cycles in WAIT_DONE
    send(CMD_START_OP, 3'd4, 3'd4, 3'd2, 8'h00);
    wait_op_req();
    bus.op_ack = 1'b1; tick(); bus.op_ack = 1'b0;
    repeat (TMO - 1) tick();
    chk("tmo_busy_before", 8'(bus.busy), 8'h01);
    tick();
    ref_err[2] = 1'b1;
    chk("tmo_busy_after", 8'(bus.busy), 8'h00);
    chk("tmo_err", 8'(bus.err), 8'(ref_err));
    bus.op_done = 1'b1; tick(); bus.op_done = 1'b0;
    chk("tmo_late_done", 8'(bus.err), 8'(ref_err));
    send(CMD_CLR_ERR, 3'd0, 3'd0, 3'd0, 8'h00); ref_err = 3'b000;
    tick(); tick();
    chk("tmo_clr", 8'(bus.err), 8'(ref_err));
`endif

    // Reset while in WAIT_ACK with a frame queued
    send(CMD_WR_TILE, 3'd7, 3'd7, 3'd0, 8'h3C); ref_mem[63] = 8'h3C;
    send(CMD_START_OP, 3'd2, 3'd2, 3'd5, 8'h00);
    wait_op_req();
    send(CMD_WR_TILE, 3'd6, 3'd6, 3'd0, 8'h99);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 64; k++) ref_mem[k] = 8'h00;
    ref_dout = 8'h00; ref_err = 3'b000;
    chk("arst_op_req",  8'(bus.op_req), 8'h00);
    chk("arst_dout",    bus.data_out, ref_dout);
    chk("arst_busy",    8'(bus.busy), 8'h00);
    peek(6'h3F, rd); chk("arst_mem_3f", rd, ref_mem[63]);
    peek(6'h15, rd); chk("arst_mem_15", rd, ref_mem[6'h15]);
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_busy", 8'(bus.busy), 8'h00);
    peek(6'h36, rd); chk("post_rst_fifo_flushed", rd, ref_mem[6'h36]);

    // Randomized tile traffic against the model
    for (int n = 0; n < 24; n++) begin
      a = 6'($urandom_range(0, 63));
      wd[0] = 8'($urandom);
      send(CMD_WR_TILE, a[5:3], a[2:0], 3'($urandom), wd[0]);
      ref_mem[a] = wd[0];
      tick();
      if ($urandom_range(0, 1) == 1) tick();
    end
    repeat (4) tick();
    chk("rand_err", 8'(bus.err), 8'(ref_err));
    for (int n = 0; n < 12; n++) begin
      a = 6'($urandom_range(0, 63));
      send(CMD_RD_TILE, a[5:3], a[2:0], 3'd0, 8'h00);
      ref_dout = ref_mem[a];
      tick(); tick();
      chk($sformatf("rand_rd_%02h", a), bus.data_out, ref_dout);
      a = 6'($urandom_range(0, 63));
      peek(a, rd);
      chk($sformatf("rand_port_%02h", a), rd, ref_mem[a]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
